// File: rtl/cache_mem_arbiter.sv
// Purpose: arbitrates the single-port RAM between icache and dcache. Data side wins, with a cap on the icache wait.
// Latency: a grant starts the cycle after the request is seen in IDLE. Completion is the first ACCESS cycle; wait is low only in that cycle.
// Backpressure: FREE/BUSY/ERROR from the RAM hold the grant and keep the wait high. ERROR re-presents the same request.
`timescale 1ns/1ps
module cache_mem_arbiter #(
    parameter int MAX_D_BURST = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2
    } state_e;

    // Only ACCESS changes the FSM. FREE, BUSY and ERROR all mean "hold the grant".
    localparam logic [1:0] RS_ACCESS = 2'd2;
    // The burst counter is 4 bits because MAX_D_BURST is limited to 1..15.
    localparam logic [3:0] MAX_B     = 4'(MAX_D_BURST);

    state_e     state_q, state_d;
    logic [3:0] dburst_q, dburst_d;

    logic dreq;
    logic ram_acc;
    logic d_may_win;

    assign dreq    = dREN | dWEN;
    assign ram_acc = (ramstate == RS_ACCESS);
    // The dcache keeps priority until it has won MAX_D_BURST completions in a row
    // while a fetch was waiting. After that, the fetch goes first.
    assign d_may_win = !iREN || (dburst_q < MAX_B);

    // State and burst counter registers. The async reset returns the FSM to IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            dburst_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            dburst_q <= dburst_d;
        end
    end

    // Next-state, burst accounting and all combinational RAM/wait outputs.
    always_comb begin
        state_d  = state_q;
        dburst_d = dburst_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                // IDLE drives nothing toward the RAM, so there is always
                // one dead cycle between two grants.
                if (dreq && d_may_win) begin
                    state_d = SERV_D;
                end else if (iREN) begin
                    state_d = SERV_I;
                end
            end

            SERV_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    // The fetch was abandoned (for example on halt). Drop the grant
                    // with no wait pulse and leave the burst count unchanged.
                    state_d = IDLE;
                end else if (ram_acc) begin
                    iwait    = 1'b0;
                    iload    = ramload;
                    state_d  = IDLE;
                    dburst_d = 4'd0;
                end
            end

            SERV_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ram_acc) begin
                    dwait   = 1'b0;
                    dload   = dREN ? ramload : '0;
                    state_d = IDLE;
                    // Count only data completions that held off a waiting fetch.
                    // The count saturates so the fetch always wins the next arbitration.
                    if (iREN) begin
                        dburst_d = (dburst_q < MAX_B) ? 4'(dburst_q + 4'd1) : dburst_q;
                    end else begin
                        dburst_d = 4'd0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
